// File: rtl/top_precedence_regblock.sv
// APB4 slave register block holding R1 with two hardware-updated fields.
// f_sw: a software write wins over the hardware next value for that cycle.
// f_hw: the hardware next value always wins; software writes are discarded.
// Zero-wait-state slave: requests are taken in the setup phase and the
// registered response appears in the first access-phase cycle.
module top_precedence_regblock #(
  parameter int G_ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_apb_psel,
  input  logic                    s_apb_penable,
  input  logic                    s_apb_pwrite,
  input  logic [2:0]              s_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0] s_apb_paddr,
  input  logic [31:0]             s_apb_pwdata,
  input  logic [3:0]              s_apb_pstrb,
  output logic                    s_apb_pready,
  output logic [31:0]             s_apb_prdata,
  output logic                    s_apb_pslverr,
  input  logic                    hwif_in_r1_f_sw_next,
  input  logic                    hwif_in_r1_f_hw_next
);

  logic        f_sw_q, f_sw_d;
  logic        f_hw_q, f_hw_d;
  logic        pready_q, pready_d;
  logic [31:0] prdata_q, prdata_d;

  logic req_s;
  logic hit_s;
  logic sw_wr_s;
  logic unused_s;

  // A request is accepted only in the setup phase; R1 decodes on the word
  // address so the byte-lane bits paddr[1:0] do not matter.
  assign req_s   = s_apb_psel & ~s_apb_penable;
  assign hit_s   = (s_apb_paddr[G_ADDR_WIDTH-1:2] == {(G_ADDR_WIDTH-2){1'b0}});
  assign sw_wr_s = req_s & s_apb_pwrite & hit_s & s_apb_pstrb[0];

  // Inputs with no function in this map, folded so they are visibly consumed.
  assign unused_s = ^{s_apb_pprot, s_apb_pwdata[31:1], s_apb_pstrb[3:1],
                      s_apb_paddr[1:0]};

  // Next-state for the fields and the registered APB response.
  always_comb begin
    f_sw_d   = hwif_in_r1_f_sw_next;
    f_hw_d   = hwif_in_r1_f_hw_next;
    pready_d = 1'b0;
    prdata_d = 32'h0000_0000;
    if (sw_wr_s) begin
      f_sw_d = s_apb_pwdata[0];
    end else begin
      f_sw_d = hwif_in_r1_f_sw_next;
    end
    if (req_s) begin
      pready_d = 1'b1;
      if (!s_apb_pwrite && hit_s) begin
        prdata_d = {30'h0000_0000, f_hw_q, f_sw_q};
      end else begin
        prdata_d = 32'h0000_0000;
      end
    end else begin
      pready_d = 1'b0;
      prdata_d = 32'h0000_0000;
    end
  end

  // State registers; reset also drops any pending response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_sw_q   <= 1'b0;
      f_hw_q   <= 1'b0;
      pready_q <= 1'b0;
      prdata_q <= 32'h0000_0000;
    end else begin
      f_sw_q   <= f_sw_d;
      f_hw_q   <= f_hw_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
    end
  end

  assign s_apb_pready  = pready_q;
  assign s_apb_prdata  = prdata_q;
  assign s_apb_pslverr = 1'b0;

endmodule

// File: tb/tb_top_precedence_regblock.sv
// Self-checking bench for top_precedence_regblock: table of APB transfers
// with a response scoreboard, plus hand-written precedence/reset sequences.
module tb_top_precedence_regblock;

  logic        clk;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [2:0]  pprot;
  logic [2:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        sw_next;
  logic        hw_next;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        sw_n;
    logic        hw_n;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  top_precedence_regblock #(.G_ADDR_WIDTH(3)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_apb_psel           (psel),
    .s_apb_penable        (penable),
    .s_apb_pwrite         (pwrite),
    .s_apb_pprot          (pprot),
    .s_apb_paddr          (paddr),
    .s_apb_pwdata         (pwdata),
    .s_apb_pstrb          (pstrb),
    .s_apb_pready         (pready),
    .s_apb_prdata         (prdata),
    .s_apb_pslverr        (pslverr),
    .hwif_in_r1_f_sw_next (sw_next),
    .hwif_in_r1_f_hw_next (hw_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge. Drives setup, checks the single-cycle response and
  // returns at the negedge after the access phase with the bus idle.
  // When chk_f is set, the field state right after the setup edge is checked.
  task automatic apb_xfer(input logic wr, input logic [2:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] exp, input logic chk_f,
                          input logic [1:0] exp_f, input string name);
    logic [31:0] e;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    pprot   = 3'b010;
    exp_q.push_back(exp);
    @(negedge clk);
    chk({name, ".pready"}, {31'd0, pready}, 32'd1);
    e = exp_q.pop_front();
    chk({name, ".prdata"}, prdata, e);
    chk({name, ".pslverr"}, {31'd0, pslverr}, 32'd0);
    if (chk_f) begin
      chk({name, ".fields"}, {30'd0, dut.f_hw_q, dut.f_sw_q}, {30'd0, exp_f});
    end
    penable = 1'b1;
    @(negedge clk);
    chk({name, ".pready_drop"}, {31'd0, pready}, 32'd0);
    chk({name, ".prdata_idle"}, prdata, 32'd0);
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  // Apply hardware next values and let the fields settle for two edges.
  task automatic settle(input logic sw, input logic hw);
    sw_next = sw;
    hw_next = hw;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pprot = 3'b000;
    paddr = 3'd0; pwdata = 32'd0; pstrb = 4'h0;
    sw_next = 1'b1; hw_next = 1'b1;
    rst = 1'b0;

    //            wr    addr  wdata          strb  sw    hw    exp
    vecs[0] = '{1'b0, 3'd0, 32'h0,         4'hF, 1'b1, 1'b1, 32'h3};
    vecs[1] = '{1'b0, 3'd0, 32'h0,         4'hF, 1'b0, 1'b1, 32'h2};
    vecs[2] = '{1'b0, 3'd0, 32'h0,         4'hF, 1'b1, 1'b0, 32'h1};
    vecs[3] = '{1'b0, 3'd4, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 3'd1, 32'h0,         4'hF, 1'b1, 1'b1, 32'h3};
    vecs[5] = '{1'b0, 3'd3, 32'h0,         4'hF, 1'b0, 1'b1, 32'h2};
    vecs[6] = '{1'b0, 3'd6, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 3'd4, 32'h3,         4'hF, 1'b1, 1'b1, 32'h0};
    vecs[9] = '{1'b0, 3'd0, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0};

    // Reset held with both next inputs high, even with a request on the bus.
    repeat (3) @(negedge clk);
    psel = 1'b1;
    @(negedge clk);
    chk("rst.pready", {31'd0, pready}, 32'd0);
    chk("rst.prdata", prdata, 32'd0);
    chk("rst.pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst.fields", {30'd0, dut.f_hw_q, dut.f_sw_q}, 32'd0);
    psel = 1'b0;
    sw_next = 1'b0; hw_next = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    apb_xfer(1'b0, 3'd0, 32'h0, 4'hF, 32'h0, 1'b0, 2'b00, "rst_read");

    // Table of single transfers.
    for (int i = 0; i < 10; i++) begin
      settle(vecs[i].sw_n, vecs[i].hw_n);
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
               vecs[i].exp, 1'b0, 2'b00, $sformatf("vec%0d", i));
    end

    // Software precedence: f_sw takes pwdata[0] for one cycle, f_hw ignores it.
    settle(1'b0, 1'b0);
    apb_xfer(1'b1, 3'd0, 32'h3, 4'hF, 32'h0, 1'b1, 2'b01, "swprec");
    chk("swprec.revert", {30'd0, dut.f_hw_q, dut.f_sw_q}, 32'd0);
    apb_xfer(1'b0, 3'd0, 32'h0, 4'hF, 32'h0, 1'b0, 2'b00, "swprec_read");

    // Hardware precedence: write of 0 cannot clear f_hw.
    settle(1'b0, 1'b1);
    apb_xfer(1'b1, 3'd0, 32'h0, 4'hF, 32'h0, 1'b1, 2'b10, "hwprec");
    apb_xfer(1'b0, 3'd0, 32'h0, 4'hF, 32'h2, 1'b0, 2'b00, "hwprec_read");

    // Strobe and address gating keep f_sw at its hardware value.
    settle(1'b1, 1'b0);
    apb_xfer(1'b1, 3'd0, 32'h0, 4'h0, 32'h0, 1'b1, 2'b01, "strb0");
    apb_xfer(1'b1, 3'd0, 32'h0, 4'hE, 32'h0, 1'b1, 2'b01, "strbE");
    apb_xfer(1'b1, 3'd4, 32'h0, 4'hF, 32'h0, 1'b1, 2'b01, "unmapped_wr");
    settle(1'b0, 1'b0);
    apb_xfer(1'b1, 3'd0, 32'h1, 4'h1, 32'h0, 1'b1, 2'b01, "strb1");

    // Back-to-back read/write/read with no idle cycle between transfers.
    settle(1'b1, 1'b1);
    apb_xfer(1'b0, 3'd0, 32'h0, 4'hF, 32'h3, 1'b0, 2'b00, "b2b0");
    apb_xfer(1'b1, 3'd0, 32'h0, 4'hF, 32'h0, 1'b1, 2'b10, "b2b1");
    apb_xfer(1'b0, 3'd0, 32'h0, 4'hF, 32'h3, 1'b0, 2'b00, "b2b2");
    apb_xfer(1'b0, 3'd4, 32'h0, 4'hF, 32'h0, 1'b0, 2'b00, "b2b3");

    // Reset asserted while a response is pending drops it.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd0;
    @(posedge clk);
    #1;
    chk("midrst.pending", {31'd0, pready}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst.pready", {31'd0, pready}, 32'd0);
    chk("midrst.prdata", prdata, 32'd0);
    @(negedge clk);
    psel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.idle", {31'd0, pready}, 32'd0);
    chk("scoreboard.empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
